// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM FIFO arbiter.
package sram_arb_pkg;

    // Access sequencer states; every access returns to IDLE before the next.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Address MSB selecting the SRAM half holding each ring FIFO.
    localparam logic FIFO_I_SEL = 1'b0;
    localparam logic FIFO_O_SEL = 1'b1;

    // Requester identities used by the round-robin arbiter.
    typedef enum logic {
        REQ_SLAVE  = 1'b0,
        REQ_MASTER = 1'b1
    } req_id_t;

endpackage

// File: rtl/sram_fifo_arbiter_if.sv
// Word-access handshake between the two requesters and the arbiter.
// The "master" modport is the requester side, "slave" is the arbiter side.
interface sram_fifo_arbiter_if #(
    parameter int DW = 16
);
    logic          s_rd_req;
    logic          s_wr_req;
    logic [DW-1:0] s_wdata;
    logic [DW-1:0] s_rdata;
    logic          s_ack;
    logic          m_rd_req;
    logic          m_wr_req;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack;
    logic          pkt_commit;
    logic          crc_rollback;

    modport master (
        output s_rd_req, s_wr_req, s_wdata, m_rd_req, m_wr_req, m_wdata,
        output pkt_commit, crc_rollback,
        input  s_rdata, s_ack, m_rdata, m_ack
    );

    modport slave (
        input  s_rd_req, s_wr_req, s_wdata, m_rd_req, m_wr_req, m_wdata,
        input  pkt_commit, crc_rollback,
        output s_rdata, s_ack, m_rdata, m_ack
    );
endinterface

// File: rtl/sram_ring_ptr.sv
// Ring FIFO pointer set: write/read pointers, optional commit pointer,
// occupancy and full/empty. Pointers carry one extra bit so full and empty
// are distinguishable; the low AW bits are the SRAM word address.
module sram_ring_ptr #(
    parameter int AW         = 17,
    parameter bit HAS_COMMIT = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_inc,
    input  logic          rd_inc,
    input  logic          commit,
    input  logic          rollback,
    output logic [AW-1:0] wptr,
    output logic [AW-1:0] rptr,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [AW:0] wptr_reg, wptr_next, wptr_inc;
    logic [AW:0] rptr_reg, rptr_next;
    logic [AW:0] cptr_reg, cptr_next;
    logic [AW:0] raw_count;

    // Next pointers; a commit includes a write finishing in the same cycle,
    // and a rollback rewinds the write pointer to the last commit point.
    always_comb begin
        wptr_inc  = wptr_reg + {{AW{1'b0}}, wr_inc};
        wptr_next = wptr_inc;
        rptr_next = rptr_reg + {{AW{1'b0}}, rd_inc};
        cptr_next = cptr_reg;
        if (HAS_COMMIT) begin
            if (rollback) begin
                wptr_next = cptr_reg;
            end else if (commit) begin
                cptr_next = wptr_inc;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
            cptr_reg <= '0;
        end else begin
            wptr_reg <= wptr_next;
            rptr_reg <= rptr_next;
            cptr_reg <= cptr_next;
        end
    end

    // Full tracks raw writes; count/empty expose only committed data.
    assign raw_count = wptr_reg - rptr_reg;
    assign count     = HAS_COMMIT ? (cptr_reg - rptr_reg) : raw_count;
    assign full      = (raw_count == DEPTH);
    assign empty     = (count == '0);
    assign wptr      = wptr_reg[AW-1:0];
    assign rptr      = rptr_reg[AW-1:0];

endmodule

// File: rtl/sram_fifo_arbiter.sv
// Arbitrates slave and master word accesses onto one async SRAM holding
// FIFO_I (slave->master) and FIFO_O (master->slave, with packet commit
// and CRC rollback), and sequences the SRAM strobes.
module sram_fifo_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW      = 17,
    parameter int DW      = 16,
    parameter int ACC_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    sram_fifo_arbiter_if.slave bus,
    output logic [AW:0]     fifo_i_count,
    output logic            fifo_i_empty,
    output logic            fifo_i_full,
    output logic [AW:0]     fifo_o_count,
    output logic            fifo_o_empty,
    output logic            fifo_o_full,
    output logic [AW:0]     mem_addr,
    output logic [DW-1:0]   dq_out,
    output logic            dq_oe,
    input  logic [DW-1:0]   dq_in,
    output logic            CE_n,
    output logic            OE_n,
    output logic            WE_n,
    output logic            LB_n,
    output logic            UB_n
);
    localparam logic [2:0] LAST_CYC = 3'(ACC_CYC - 1);

    state_t        state_reg, state_next;
    logic [2:0]    cnt_reg, cnt_next;
    req_id_t       last_reg, gnt_id_reg, grant_id;
    logic          gnt_wr_reg, gnt_fifo_reg;
    logic          grant_valid, grant_wr, grant_fifo;
    logic [AW-1:0] grant_ptr;
    logic [AW:0]   addr_reg;
    logic [DW-1:0] wdata_reg, rdata_reg;
    logic          rb_pending_reg;
    logic          s_wr_ok, s_rd_ok, s_ok, m_wr_ok, m_rd_ok, m_ok;
    logic          in_access, done, rb_apply, commit_o;

    logic [AW-1:0] wptr_a [2];
    logic [AW-1:0] rptr_a [2];
    logic [AW:0]   count_a [2];
    logic          full_a [2];
    logic          empty_a [2];
    logic          wr_inc_a [2];
    logic          rd_inc_a [2];
    logic          commit_a [2];
    logic          rollback_a [2];

    assign done     = (state_reg == ST_DONE);
    assign rb_apply = rb_pending_reg && (state_reg == ST_IDLE);
    // A rollback arriving with a commit cancels that commit.
    assign commit_o = bus.pkt_commit && !bus.crc_rollback;

    // One pointer set per SRAM half; only FIFO_O gets commit/rollback.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        assign wr_inc_a[gi]   = done && gnt_wr_reg && (gnt_fifo_reg == 1'(gi));
        assign rd_inc_a[gi]   = done && !gnt_wr_reg && (gnt_fifo_reg == 1'(gi));
        assign commit_a[gi]   = (gi == 1) && commit_o;
        assign rollback_a[gi] = (gi == 1) && rb_apply;

        sram_ring_ptr #(
            .AW         (AW),
            .HAS_COMMIT (gi == 1)
        ) u_ptr (
            .clk      (clk),
            .rst      (rst),
            .wr_inc   (wr_inc_a[gi]),
            .rd_inc   (rd_inc_a[gi]),
            .commit   (commit_a[gi]),
            .rollback (rollback_a[gi]),
            .wptr     (wptr_a[gi]),
            .rptr     (rptr_a[gi]),
            .count    (count_a[gi]),
            .full     (full_a[gi]),
            .empty    (empty_a[gi])
        );
    end

    assign fifo_i_count = count_a[FIFO_I_SEL];
    assign fifo_i_empty = empty_a[FIFO_I_SEL];
    assign fifo_i_full  = full_a[FIFO_I_SEL];
    assign fifo_o_count = count_a[FIFO_O_SEL];
    assign fifo_o_empty = empty_a[FIFO_O_SEL];
    assign fifo_o_full  = full_a[FIFO_O_SEL];

    // Eligibility: writes need room, reads need (committed) data, and the
    // master may not write FIFO_O until a pending rollback has been applied.
    assign s_wr_ok = bus.s_wr_req && !fifo_i_full;
    assign s_rd_ok = bus.s_rd_req && !fifo_o_empty;
    assign s_ok    = s_wr_ok || s_rd_ok;
    assign m_wr_ok = bus.m_wr_req && !fifo_o_full && !rb_pending_reg;
    assign m_rd_ok = bus.m_rd_req && !fifo_i_empty;
    assign m_ok    = m_wr_ok || m_rd_ok;

    // Next-state logic with round-robin grant taken in IDLE.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        grant_valid = 1'b0;
        grant_id    = REQ_SLAVE;
        grant_wr    = 1'b0;
        grant_fifo  = FIFO_I_SEL;
        grant_ptr   = '0;
        case (state_reg)
            ST_IDLE: begin
                if (s_ok && m_ok) begin
                    grant_id = (last_reg == REQ_MASTER) ? REQ_SLAVE : REQ_MASTER;
                end else if (m_ok) begin
                    grant_id = REQ_MASTER;
                end
                grant_valid = s_ok || m_ok;
                grant_wr    = (grant_id == REQ_SLAVE) ? s_wr_ok : m_wr_ok;
                // Slave writes FIFO_I and reads FIFO_O; master the reverse.
                if (grant_id == REQ_SLAVE) begin
                    grant_fifo = grant_wr ? FIFO_I_SEL : FIFO_O_SEL;
                end else begin
                    grant_fifo = grant_wr ? FIFO_O_SEL : FIFO_I_SEL;
                end
                grant_ptr = grant_wr ? wptr_a[grant_fifo] : rptr_a[grant_fifo];
                if (grant_valid) begin
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_next   = '0;
                state_next = ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt_reg == LAST_CYC) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, grant capture, data latching and rollback flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            last_reg       <= REQ_MASTER;
            gnt_id_reg     <= REQ_SLAVE;
            gnt_wr_reg     <= 1'b0;
            gnt_fifo_reg   <= FIFO_I_SEL;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
            rb_pending_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (grant_valid) begin
                gnt_id_reg   <= grant_id;
                gnt_wr_reg   <= grant_wr;
                gnt_fifo_reg <= grant_fifo;
                addr_reg     <= {grant_fifo, grant_ptr};
                if (grant_wr) begin
                    wdata_reg <= (grant_id == REQ_SLAVE) ? bus.s_wdata : bus.m_wdata;
                end
            end
            if ((state_reg == ST_STROBE) && (cnt_reg == LAST_CYC) && !gnt_wr_reg) begin
                rdata_reg <= dq_in;
            end
            if (done) begin
                last_reg <= gnt_id_reg;
            end
            if (bus.crc_rollback) begin
                rb_pending_reg <= 1'b1;
            end else if (state_reg == ST_IDLE) begin
                rb_pending_reg <= 1'b0;
            end
        end
    end

    // SRAM pin and ack decode from the current state.
    assign in_access = (state_reg == ST_SETUP) || (state_reg == ST_STROBE);
    assign CE_n      = !in_access;
    assign LB_n      = !in_access;
    assign UB_n      = !in_access;
    assign OE_n      = !((state_reg == ST_STROBE) && !gnt_wr_reg);
    assign WE_n      = !((state_reg == ST_STROBE) && gnt_wr_reg);
    assign dq_oe     = in_access && gnt_wr_reg;
    assign dq_out    = wdata_reg;
    assign mem_addr  = addr_reg;

    assign bus.s_ack   = done && (gnt_id_reg == REQ_SLAVE);
    assign bus.m_ack   = done && (gnt_id_reg == REQ_MASTER);
    assign bus.s_rdata = rdata_reg;
    assign bus.m_rdata = rdata_reg;

endmodule

// File: tb/tb_sram_fifo_arbiter.sv
// Directed bench for sram_fifo_arbiter with a behavioural SRAM model.
module tb_sram_fifo_arbiter;
    localparam int AW  = 4;
    localparam int DW  = 16;
    localparam int ACC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW:0]   fifo_i_count, fifo_o_count, mem_addr;
    logic          fifo_i_empty, fifo_i_full, fifo_o_empty, fifo_o_full;
    logic [DW-1:0] dq_out, dq_in;
    logic          dq_oe, CE_n, OE_n, WE_n, LB_n, UB_n;
    logic [DW-1:0] sram [32];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sram_fifo_arbiter_if #(.DW(DW)) bus ();

    sram_fifo_arbiter #(.AW(AW), .DW(DW), .ACC_CYC(ACC)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .fifo_i_count (fifo_i_count),
        .fifo_i_empty (fifo_i_empty),
        .fifo_i_full  (fifo_i_full),
        .fifo_o_count (fifo_o_count),
        .fifo_o_empty (fifo_o_empty),
        .fifo_o_full  (fifo_o_full),
        .mem_addr     (mem_addr),
        .dq_out       (dq_out),
        .dq_oe        (dq_oe),
        .dq_in        (dq_in),
        .CE_n         (CE_n),
        .OE_n         (OE_n),
        .WE_n         (WE_n),
        .LB_n         (LB_n),
        .UB_n         (UB_n)
    );

    // Asynchronous SRAM model.
    always @(posedge clk) begin
        if (!CE_n && !WE_n) sram[mem_addr] <= dq_out;
    end
    assign dq_in = (!CE_n && !OE_n) ? sram[mem_addr] : '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        else passed++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", {27'd0, CE_n, OE_n, WE_n, LB_n, UB_n}, 32'h1F);
        chk("rst_dq_oe", {31'd0, dq_oe}, 0);
        chk("rst_addr", {27'd0, mem_addr}, 0);
        chk("rst_dq_out", {16'd0, dq_out}, 0);
        chk("rst_rdata", {16'd0, bus.s_rdata}, 0);
        chk("rst_acks", {30'd0, bus.s_ack, bus.m_ack}, 0);
        chk("rst_counts", {22'd0, fifo_i_count, fifo_o_count}, 0);
        chk("rst_flags", {28'd0, fifo_i_empty, fifo_o_empty, fifo_i_full, fifo_o_full}, 32'hC);
        rst = 1'b0;
    endtask

    // One word access; returns at the IDLE cycle after the ack.
    task automatic access(input bit is_m, input bit wr, input logic [DW-1:0] wd,
                          output logic [DW-1:0] rd, output int lat,
                          output logic [AW:0] addr, output int strb);
        lat = -1; rd = '0; addr = '0; strb = 0;
        if (is_m) begin
            bus.m_wr_req = wr; bus.m_rd_req = !wr; bus.m_wdata = wd;
        end else begin
            bus.s_wr_req = wr; bus.s_rd_req = !wr; bus.s_wdata = wd;
        end
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (!WE_n || !OE_n) begin strb++; addr = mem_addr; end
            if ((is_m && bus.m_ack) || (!is_m && bus.s_ack)) begin
                lat = c;
                rd = is_m ? bus.m_rdata : bus.s_rdata;
                break;
            end
        end
        bus.m_wr_req = 1'b0; bus.m_rd_req = 1'b0;
        bus.s_wr_req = 1'b0; bus.s_rd_req = 1'b0;
        @(posedge clk); #1;
        $display("access %s %s wd=%h rd=%h addr=%h lat=%0d", is_m ? "M" : "S",
                 wr ? "WR" : "RD", wd, rd, addr, lat);
    endtask

    typedef struct {
        bit            is_m;
        bit            wr;
        logic [DW-1:0] wd;
        logic [AW:0]   exp_addr;
        logic [DW-1:0] exp_rd;
        int            exp_i;
        int            exp_o;
    } vec_t;

    vec_t          vecs [6];
    logic [DW-1:0] rd;
    logic [AW:0]   addr;
    int            lat, strb, n, m_cyc, s_cyc;
    int            ack_cyc [6];
    bit            ack_m [6];
    logic [AW:0]   s_addr;

    initial begin
        bus.s_rd_req = 0; bus.s_wr_req = 0; bus.s_wdata = 0;
        bus.m_rd_req = 0; bus.m_wr_req = 0; bus.m_wdata = 0;
        bus.pkt_commit = 0; bus.crc_rollback = 0;

        vecs[0] = '{1'b0, 1'b1, 16'hA5A5, 5'h00, 16'h0000, 1, 0};
        vecs[1] = '{1'b0, 1'b1, 16'h1234, 5'h01, 16'h0000, 2, 0};
        vecs[2] = '{1'b1, 1'b0, 16'h0000, 5'h00, 16'hA5A5, 1, 0};
        vecs[3] = '{1'b1, 1'b1, 16'hBEEF, 5'h10, 16'h0000, 1, 0};
        vecs[4] = '{1'b1, 1'b0, 16'h0000, 5'h01, 16'h1234, 0, 0};
        vecs[5] = '{1'b1, 1'b1, 16'hCAFE, 5'h11, 16'h0000, 0, 0};

        // Basic accesses from reset.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            access(vecs[i].is_m, vecs[i].wr, vecs[i].wd, rd, lat, addr, strb);
            chk($sformatf("v%0d_lat", i), lat, 4);
            chk($sformatf("v%0d_strobe", i), strb, ACC);
            chk($sformatf("v%0d_addr", i), {27'd0, addr}, {27'd0, vecs[i].exp_addr});
            if (!vecs[i].wr) chk($sformatf("v%0d_rdata", i), {16'd0, rd}, {16'd0, vecs[i].exp_rd});
            chk($sformatf("v%0d_icount", i), {27'd0, fifo_i_count}, vecs[i].exp_i);
            chk($sformatf("v%0d_ocount", i), {27'd0, fifo_o_count}, vecs[i].exp_o);
        end

        // Both requesters hold writes: grants alternate S,M,... every 5 cycles.
        do_reset();
        for (int k = 0; k < 6; k++) begin ack_cyc[k] = 0; ack_m[k] = 0; end
        n = 0;
        bus.s_wr_req = 1; bus.s_wdata = 16'h5555;
        bus.m_wr_req = 1; bus.m_wdata = 16'hAAAA;
        for (int c = 1; c <= 40 && n < 6; c++) begin
            @(posedge clk); #1;
            if (bus.s_ack) begin ack_cyc[n] = c; ack_m[n] = 0; n++; end
            else if (bus.m_ack) begin ack_cyc[n] = c; ack_m[n] = 1; n++; end
        end
        bus.s_wr_req = 0; bus.m_wr_req = 0;
        @(posedge clk); #1;
        chk("rr_acks", n, 6);
        for (int k = 0; k < 6; k++) begin
            $display("rr ack %0d %s cycle %0d", k, ack_m[k] ? "M" : "S", ack_cyc[k]);
            chk($sformatf("rr%0d_who", k), {31'd0, ack_m[k]}, k % 2);
            chk($sformatf("rr%0d_cyc", k), ack_cyc[k], 4 + 5 * k);
        end
        chk("rr_icount", {27'd0, fifo_i_count}, 3);

        // Commit 3 words, roll back 2 more, next write reuses address 0x13.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            access(1, 1, 16'hD000 + 16'(i), rd, lat, addr, strb);
            chk($sformatf("cm%0d_addr", i), {27'd0, addr}, 32'h10 + i);
        end
        chk("precommit_ocount", {27'd0, fifo_o_count}, 0);
        chk("precommit_oempty", {31'd0, fifo_o_empty}, 1);
        bus.pkt_commit = 1; @(posedge clk); #1; bus.pkt_commit = 0;
        chk("commit_ocount", {27'd0, fifo_o_count}, 3);
        for (int i = 3; i < 5; i++) begin
            access(1, 1, 16'hD000 + 16'(i), rd, lat, addr, strb);
            chk($sformatf("cm%0d_addr", i), {27'd0, addr}, 32'h10 + i);
        end
        chk("uncommitted_ocount", {27'd0, fifo_o_count}, 3);
        bus.crc_rollback = 1; @(posedge clk); #1; bus.crc_rollback = 0;
        access(1, 1, 16'hE000, rd, lat, addr, strb);
        chk("rb_lat", lat, 5);
        chk("rb_addr", {27'd0, addr}, 32'h13);
        chk("rb_ocount", {27'd0, fifo_o_count}, 3);
        for (int i = 0; i < 3; i++) begin
            access(0, 0, 16'h0, rd, lat, addr, strb);
            chk($sformatf("sr%0d_addr", i), {27'd0, addr}, 32'h10 + i);
            chk($sformatf("sr%0d_data", i), {16'd0, rd}, 32'hD000 + i);
        end
        chk("drain_oempty", {31'd0, fifo_o_empty}, 1);

        // Fill FIFO_I, block a further write, then wrap around the ring.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            access(0, 1, 16'h0100 + 16'(i), rd, lat, addr, strb);
            chk($sformatf("fill%0d_lat", i), lat, 4);
        end
        chk("fill_full", {31'd0, fifo_i_full}, 1);
        chk("fill_count", {27'd0, fifo_i_count}, 16);
        bus.s_wr_req = 1; bus.s_wdata = 16'h0F0F;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (bus.s_ack) n++;
        end
        chk("full_no_ack", n, 0);
        bus.m_rd_req = 1;
        m_cyc = -1; s_cyc = -1; s_addr = '0; rd = '0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (!WE_n) s_addr = mem_addr;
            if (bus.m_ack) begin m_cyc = c; rd = bus.m_rdata; bus.m_rd_req = 0; end
            if (bus.s_ack) begin s_cyc = c; bus.s_wr_req = 0; break; end
        end
        bus.m_rd_req = 0; bus.s_wr_req = 0;
        @(posedge clk); #1;
        $display("unblock m_ack@%0d s_ack@%0d rd=%h waddr=%h", m_cyc, s_cyc, rd, s_addr);
        chk("unblock_m_cyc", m_cyc, 4);
        chk("unblock_m_data", {16'd0, rd}, 32'h0100);
        chk("unblock_s_cyc", s_cyc, 9);
        chk("wrap_waddr", {27'd0, s_addr}, 0);
        chk("wrap_count", {27'd0, fifo_i_count}, 16);
        for (int i = 0; i < 16; i++) begin
            access(1, 0, 16'h0, rd, lat, addr, strb);
            chk($sformatf("wr%0d_addr", i), {27'd0, addr}, (i + 1) % 16);
            chk($sformatf("wr%0d_data", i), {16'd0, rd}, (i < 15) ? 32'h0101 + i : 32'h0F0F);
        end
        chk("wrap_empty", {31'd0, fifo_i_empty}, 1);
        chk("wrap_end_count", {27'd0, fifo_i_count}, 0);

        // Reset during the STROBE of a write.
        access(0, 1, 16'h7777, rd, lat, addr, strb);
        chk("pre_rst_icount", {27'd0, fifo_i_count}, 1);
        bus.s_wr_req = 1; bus.s_wdata = 16'h8888;
        repeat (2) begin @(posedge clk); #1; end
        chk("mid_we_low", {31'd0, WE_n}, 0);
        rst = 1;
        @(posedge clk); #1;
        chk("mid_rst_strobes", {29'd0, WE_n, CE_n, dq_oe}, 32'h6);
        chk("mid_rst_ack", {31'd0, bus.s_ack}, 0);
        chk("mid_rst_icount", {27'd0, fifo_i_count}, 0);
        rst = 0; bus.s_wr_req = 0;
        @(posedge clk); #1;
        chk("post_rst_ack", {31'd0, bus.s_ack}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
